datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Ports, in this order:
  clock  in  1  rising-edge clock for all registers
  clear  in  1  asynchronous active-low reset
  Mdatain  in  32  memory read data
  Read  in  1  MDR input select: 1 = Mdatain, 0 = bus
  opcode  in  5  ALU operation select
  Cin  in  1  ALU carry-in for ADD/SUB
  IncPC  in  1  with PCin, PC <= PC+1 instead of bus
  PCout, MDRout, Zhighout, Zlowout, R2out, R3out  in  1 each  bus source enables
  R0in, R1in, R2in, R3in, PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin  in  1 each  register load enables
  BusMuxOut  out  32  current internal bus value
  R1_q  out  32  current R1 contents (observation port)

Function
REQ-003 Registers SHALL be 32-bit R0-R3, PC, IR, MAR, MDR, Y, HI, LO, ZHI and ZLO, all updated only on the rising clock edge.
REQ-004 The bus SHALL be combinational with fixed priority PCout > MDRout > Zhighout > Zlowout > R2out > R3out, and SHALL be 0 when no source is enabled.
REQ-005 Each of Rn, IR, MAR, Y, HI and LO SHALL load the bus value when its enable is 1, and SHALL otherwise hold.
REQ-006 When MDRin=1, MDR SHALL load Mdatain if Read=1, or the bus value if Read=0.
REQ-007 When PCin=1, PC SHALL load PC+1 (mod 2^32) if IncPC=1, or the bus value if IncPC=0; PC SHALL hold when PCin=0.
REQ-008 The ALU SHALL be combinational, with A=Y, B=bus, 64-bit result {hi,lo}, and hi=0 unless otherwise stated:
  00011 ADD: lo = A+B+Cin
  00100 SUB: lo = A-B-Cin
  00101 SHR: lo = A logically shifted right by B[4:0]
  00110 SHL: lo = A shifted left by B[4:0]
  00111 ROR: lo = A rotated right by B[4:0]
  01000 ROL: lo = A rotated left by B[4:0]
  01010 AND: lo = A & B
  01011 OR: lo = A | B
  01111 MUL: {hi,lo} = signed A*B, full 64 bits
  10000 DIV: lo = signed quotient truncated toward zero, hi = remainder with the sign of A
  10001 NEG: lo = -B
  10010 NOT: lo = ~B
  any other code: {hi,lo} = 0
REQ-009 DIV with B=0 SHALL produce lo=32'hFFFFFFFF and hi=A.
REQ-010 Zlowin=1 SHALL load ZLO from ALU lo, and Zhighin=1 SHALL load ZHI from ALU hi; the two loads are independent.
REQ-011 When a register is both a bus source and a load target in the same cycle, it SHALL load the pre-edge bus value.
REQ-012 Each register-to-register transfer SHALL complete in one clock; an ALU operation SHALL take 3 clocks (Y load, Z load, Z to destination).
REQ-013 BusMuxOut and R1_q SHALL be purely combinational views.

Reset
REQ-014 While clear=0, every register SHALL be 0 immediately, without waiting for a clock edge, and all loads SHALL be ignored.
REQ-015 After clear returns to 1, operation SHALL resume on the next rising edge.
REQ-016 A reset asserted mid-sequence SHALL abort the sequence; no partial state is retained.

Verification
REQ-017 Register load:
  - Mdatain=0x12, Read=1, MDRin=1 for one edge, then MDRout=1, R2in=1 for one edge -> R2=0x12.
  - Repeat with 0x14 into R3 and 0x18 into R1 -> R1_q=0x18.
REQ-018 PC increment: from reset, PCin=1, IncPC=1 for one edge -> PC=1; with PCout=1 on the next cycle, BusMuxOut=1.
REQ-019 Instruction fetch: Mdatain=0x28918000 into MDR, then MDRout=1, IRin=1 -> IR=0x28918000.
REQ-020 AND: with R2=0x12, R3=0x14:
  - R2out=1, Yin=1 for one edge.
  - R3out=1, opcode=01010, Zlowin=1 for one edge.
  - Zlowout=1, R1in=1 for one edge.
  - Result: R1_q=0x10, ZHI unchanged.
REQ-021 MUL/DIV, with Y=-6 and B=4:
  - MUL -> {ZHI,ZLO} = 64'hFFFFFFFF_FFFFFFE8.
  - DIV -> ZLO = -1, ZHI = -2.
  - DIV with B=0 -> ZLO = 0xFFFFFFFF, ZHI = -6.
REQ-022 Reset: drive clear=0 between clock edges -> all registers and R1_q read 0 immediately; a clock edge with R1in=1 while clear=0 leaves R1=0.

Source files
------------

// File: rtl/datapath.sv
// Single-bus CPU datapath: thirteen 32-bit registers around one shared
// internal bus, plus a combinational ALU that feeds the Z register pair.
//
// Ports:
//   clock, clear          rising-edge clock, asynchronous active-low reset
//   Mdatain, Read         memory read data and MDR input select (1 = memory)
//   opcode, Cin           ALU operation select and carry/borrow in
//   IncPC                 with PCin, PC increments instead of loading the bus
//   *out                  bus source enables (fixed priority, PC highest)
//   *in                   register load enables
//   BusMuxOut             current internal bus value (combinational)
//   R1_q                  current R1 contents (combinational view)
module datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] Mdatain,
    input  logic        Read,
    input  logic [4:0]  opcode,
    input  logic        Cin,
    input  logic        IncPC,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Zhighin,
    input  logic        Zlowin,
    output logic [31:0] BusMuxOut,
    output logic [31:0] R1_q
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 13;
    localparam int unsigned RF_IDX_W = 4;

    localparam logic [RF_IDX_W-1:0] RF_R0  = 4'd0;
    localparam logic [RF_IDX_W-1:0] RF_R1  = 4'd1;
    localparam logic [RF_IDX_W-1:0] RF_R2  = 4'd2;
    localparam logic [RF_IDX_W-1:0] RF_R3  = 4'd3;
    localparam logic [RF_IDX_W-1:0] RF_PC  = 4'd4;
    localparam logic [RF_IDX_W-1:0] RF_IR  = 4'd5;
    localparam logic [RF_IDX_W-1:0] RF_MAR = 4'd6;
    localparam logic [RF_IDX_W-1:0] RF_MDR = 4'd7;
    localparam logic [RF_IDX_W-1:0] RF_Y   = 4'd8;
    localparam logic [RF_IDX_W-1:0] RF_HI  = 4'd9;
    localparam logic [RF_IDX_W-1:0] RF_LO  = 4'd10;
    localparam logic [RF_IDX_W-1:0] RF_ZHI = 4'd11;
    localparam logic [RF_IDX_W-1:0] RF_ZLO = 4'd12;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    logic [DATA_W-1:0]          rf [NUM_REGS];
    logic [DATA_W-1:0]          bus;
    logic [DATA_W-1:0]          alu_a;
    logic [DATA_W-1:0]          alu_b;
    logic [DATA_W-1:0]          alu_hi;
    logic [DATA_W-1:0]          alu_lo;
    logic [4:0]                 shamt;
    logic signed [DATA_W-1:0]   sa;
    logic signed [DATA_W-1:0]   sb;
    logic signed [2*DATA_W-1:0] mul_full;

    // Bus source mux, fixed priority; idle bus reads zero.
    always_comb begin
        bus = '0;
        if (PCout)         bus = rf[RF_PC];
        else if (MDRout)   bus = rf[RF_MDR];
        else if (Zhighout) bus = rf[RF_ZHI];
        else if (Zlowout)  bus = rf[RF_ZLO];
        else if (R2out)    bus = rf[RF_R2];
        else if (R3out)    bus = rf[RF_R3];
    end

    assign alu_a    = rf[RF_Y];
    assign alu_b    = bus;
    assign shamt    = alu_b[4:0];
    assign sa       = $signed(alu_a);
    assign sb       = $signed(alu_b);
    assign mul_full = 64'(sa) * 64'(sb);

    // ALU: rotates use a doubled operand so a zero shift amount needs no special case.
    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (opcode)
            OP_ADD: alu_lo = alu_a + alu_b + 32'(Cin);
            OP_SUB: alu_lo = alu_a - alu_b - 32'(Cin);
            OP_SHR: alu_lo = alu_a >> shamt;
            OP_SHL: alu_lo = alu_a << shamt;
            OP_ROR: alu_lo = 32'({alu_a, alu_a} >> shamt);
            OP_ROL: alu_lo = 32'(({alu_a, alu_a} << shamt) >> DATA_W);
            OP_AND: alu_lo = alu_a & alu_b;
            OP_OR:  alu_lo = alu_a | alu_b;
            OP_MUL: begin
                alu_hi = mul_full[2*DATA_W-1:DATA_W];
                alu_lo = mul_full[DATA_W-1:0];
            end
            OP_DIV: begin
                // Divide by zero returns all-ones quotient and passes the dividend through.
                if (alu_b == '0) begin
                    alu_lo = '1;
                    alu_hi = alu_a;
                end else begin
                    alu_lo = 32'(sa / sb);
                    alu_hi = 32'(sa % sb);
                end
            end
            OP_NEG: alu_lo = 32'(0) - alu_b;
            OP_NOT: alu_lo = ~alu_b;
            default: begin
                alu_hi = '0;
                alu_lo = '0;
            end
        endcase
    end

    // Register file; every load samples the pre-edge bus, so self-transfers are safe.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rf <= '{default: '0};
        end else begin
            if (R0in)    rf[RF_R0]  <= bus;
            if (R1in)    rf[RF_R1]  <= bus;
            if (R2in)    rf[RF_R2]  <= bus;
            if (R3in)    rf[RF_R3]  <= bus;
            if (PCin)    rf[RF_PC]  <= IncPC ? rf[RF_PC] + 32'd1 : bus;
            if (IRin)    rf[RF_IR]  <= bus;
            if (MARin)   rf[RF_MAR] <= bus;
            if (MDRin)   rf[RF_MDR] <= Read ? Mdatain : bus;
            if (Yin)     rf[RF_Y]   <= bus;
            if (HIin)    rf[RF_HI]  <= bus;
            if (LOin)    rf[RF_LO]  <= bus;
            if (Zhighin) rf[RF_ZHI] <= alu_hi;
            if (Zlowin)  rf[RF_ZLO] <= alu_lo;
        end
    end

    assign BusMuxOut = bus;
    assign R1_q      = rf[RF_R1];

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: expected values are queued when a
// micro-sequence is driven and popped when the matching output is sampled.
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        Read;
    logic [4:0]  opcode;
    logic        Cin, IncPC;
    logic        PCout, MDRout, Zhighout, Zlowout, R2out, R3out;
    logic        R0in, R1in, R2in, R3in, PCin, IRin, MARin, MDRin;
    logic        Yin, HIin, LOin, Zhighin, Zlowin;
    logic [31:0] BusMuxOut;
    logic [31:0] R1_q;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
        .opcode(opcode), .Cin(Cin), .IncPC(IncPC),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .R2out(R2out), .R3out(R3out),
        .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in), .PCin(PCin),
        .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .BusMuxOut(BusMuxOut), .R1_q(R1_q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        if (exp_q.size() == 0) check("sb_empty", obs, ~obs);
        else check(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    task automatic clr_ctl();
        Read = 0; opcode = 5'd0; Cin = 0; IncPC = 0;
        PCout = 0; MDRout = 0; Zhighout = 0; Zlowout = 0; R2out = 0; R3out = 0;
        R0in = 0; R1in = 0; R2in = 0; R3in = 0; PCin = 0; IRin = 0; MARin = 0;
        MDRin = 0; Yin = 0; HIin = 0; LOin = 0; Zhighin = 0; Zlowin = 0;
    endtask

    // One clock edge, then controls drop back to idle between edges.
    task automatic tick();
        @(posedge clock);
        #1;
        clr_ctl();
    endtask

    // Sample the bus with whatever sources the caller enabled.
    task automatic sample_bus(input string tag, input logic [31:0] v);
        expect_out(tag, v);
        #1;
        observe(BusMuxOut);
        clr_ctl();
    endtask

    task automatic sample_r1(input string tag, input logic [31:0] v);
        expect_out(tag, v);
        #1;
        observe(R1_q);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
    endtask

    // Y <- a, Z <- alu(a, b); then read ZLO and ZHI back over the bus.
    task automatic run_alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic cin,
                           input logic [31:0] hi, input logic [31:0] lo);
        load_mdr(a);
        MDRout = 1; Yin = 1; tick();
        load_mdr(b);
        MDRout = 1; opcode = op; Cin = cin; Zlowin = 1; Zhighin = 1; tick();
        Zlowout = 1;  sample_bus({tag, "_lo"}, lo);
        Zhighout = 1; sample_bus({tag, "_hi"}, hi);
    endtask

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a, b;
        logic        cin;
        logic [31:0] hi, lo;
    } alu_vec_t;

    alu_vec_t vecs[$];

    initial begin
        clr_ctl();
        Mdatain = '0;
        clear = 0;
        #3;
        PCout = 1; sample_bus("rst_bus_pc", 32'h0);
        sample_r1("rst_r1", 32'h0);
        #1 clear = 1;

        // PC increment from reset, then bus load and wrap-around.
        PCin = 1; IncPC = 1; tick();
        PCout = 1; sample_bus("pc_inc", 32'h1);
        load_mdr(32'hFFFF_FFFF);
        MDRout = 1; PCin = 1; tick();
        PCout = 1; sample_bus("pc_load", 32'hFFFF_FFFF);
        PCin = 1; IncPC = 1; tick();
        PCout = 1; sample_bus("pc_wrap", 32'h0);

        // Register loads through MDR.
        load_mdr(32'h12); MDRout = 1; R2in = 1; tick();
        load_mdr(32'h14); MDRout = 1; R3in = 1; tick();
        load_mdr(32'h18); MDRout = 1; R1in = 1; tick();
        sample_r1("r1_load", 32'h18);
        R2out = 1; sample_bus("r2_load", 32'h12);
        R3out = 1; sample_bus("r3_load", 32'h14);

        // Instruction fetch, then MDR loading from the bus (Read=0).
        load_mdr(32'h2891_8000); MDRout = 1; IRin = 1; tick();
        R3out = 1; MDRin = 1; tick();
        MDRout = 1; sample_bus("mdr_from_bus", 32'h14);

        // Bus priority (PC=0, MDR=0x14, R2=0x12, R3=0x14).
        PCout = 1; MDRout = 1; R2out = 1; sample_bus("prio_pc", 32'h0);
        load_mdr(32'hA5A5_0001);
        MDRout = 1; Zlowout = 1; R2out = 1; sample_bus("prio_mdr", 32'hA5A5_0001);
        R2out = 1; R3out = 1; sample_bus("prio_r2", 32'h12);
        sample_bus("bus_idle", 32'h0);

        // Source and target in the same cycle: R3 -> R3 and R1.
        R3out = 1; R3in = 1; R1in = 1; tick();
        sample_r1("self_r1", 32'h14);
        R3out = 1; sample_bus("self_r3", 32'h14);

        // ALU vectors.
        vecs.push_back('{"add",  5'b00011, 32'h12, 32'h14, 1'b1, 32'h0, 32'h27});
        vecs.push_back('{"sub",  5'b00100, 32'h12, 32'h14, 1'b0, 32'h0, 32'hFFFF_FFFE});
        vecs.push_back('{"subc", 5'b00100, 32'h20, 32'h10, 1'b1, 32'h0, 32'h0F});
        vecs.push_back('{"shr",  5'b00101, 32'h8000_0010, 32'h4, 1'b0, 32'h0, 32'h0800_0001});
        vecs.push_back('{"shl",  5'b00110, 32'h8000_0010, 32'h24, 1'b0, 32'h0, 32'h0000_0100});
        vecs.push_back('{"ror",  5'b00111, 32'h8000_0011, 32'h4, 1'b0, 32'h0, 32'h1800_0001});
        vecs.push_back('{"ror0", 5'b00111, 32'h8000_0011, 32'h20, 1'b0, 32'h0, 32'h8000_0011});
        vecs.push_back('{"rol",  5'b01000, 32'h8000_0011, 32'h4, 1'b0, 32'h0, 32'h0000_0118});
        vecs.push_back('{"or",   5'b01011, 32'h12, 32'h14, 1'b0, 32'h0, 32'h16});
        vecs.push_back('{"mul",  5'b01111, 32'hFFFF_FFFA, 32'h4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE8});
        vecs.push_back('{"mulb", 5'b01111, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h1, 32'h0});
        vecs.push_back('{"div",  5'b10000, 32'hFFFF_FFFA, 32'h4, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF});
        vecs.push_back('{"div7", 5'b10000, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'h1, 32'hFFFF_FFFD});
        vecs.push_back('{"neg",  5'b10001, 32'h1, 32'h5, 1'b0, 32'h0, 32'hFFFF_FFFB});
        vecs.push_back('{"not",  5'b10010, 32'h1, 32'h0F0F_0F0F, 1'b0, 32'h0, 32'hF0F0_F0F0});
        vecs.push_back('{"bad",  5'b00000, 32'h1234, 32'h5678, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"div0", 5'b10000, 32'hFFFF_FFFA, 32'h0, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFF});
        foreach (vecs[i])
            run_alu(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hi, vecs[i].lo);

        // AND over R2/R3; only ZLO loads so ZHI keeps the div0 remainder.
        R2out = 1; Yin = 1; tick();
        R3out = 1; opcode = 5'b01010; Zlowin = 1; tick();
        Zlowout = 1; R1in = 1; tick();
        sample_r1("and_r1", 32'h10);
        Zhighout = 1; sample_bus("and_zhi", 32'hFFFF_FFFA);

        // Reset mid-sequence: Y loaded, then clear between edges.
        load_mdr(32'h55);
        MDRout = 1; Yin = 1; tick();
        clear = 0;
        sample_r1("clr_r1_now", 32'h0);
        MDRout = 1; sample_bus("clr_mdr_now", 32'h0);
        Mdatain = 32'h77; Read = 1; MDRin = 1; R1in = 1; PCin = 1; IncPC = 1;
        Zlowin = 1; opcode = 5'b10010;
        tick();
        sample_r1("clr_edge_r1", 32'h0);
        MDRout = 1; sample_bus("clr_edge_mdr", 32'h0);
        PCout = 1; sample_bus("clr_edge_pc", 32'h0);
        Zlowout = 1; sample_bus("clr_edge_zlo", 32'h0);
        clear = 1;

        // After release Y must be zero: ADD 0 + 3.
        load_mdr(32'h3);
        MDRout = 1; opcode = 5'b00011; Zlowin = 1; tick();
        Zlowout = 1; sample_bus("post_clr_y", 32'h3);
        PCin = 1; IncPC = 1; tick();
        PCout = 1; sample_bus("post_clr_pc", 32'h1);

        if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
